mips_data_mem: RTL and testbench
================================

MIPS_DATA_MEM -- requirements
Module: mips_data_mem

Interface
REQ-001 The module SHALL have parameter MEM_BYTES, default 8192: data memory size in bytes; power of two, at least 16.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst_b, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port mem_addr, input, 32 bits: byte address of lane 0 of the access.
REQ-005 The module SHALL have port mem_data_in, input, [7:0] x [0:3]: write data; lane i goes to byte mem_addr+i.
REQ-006 The module SHALL have port mem_write_en, input, 1 bit: write request for the current cycle.
REQ-007 The module SHALL have port mem_data_out, output, [7:0] x [0:3]: read data; lane i = byte mem_addr+i.
REQ-008 The module SHALL have port mem_ready, output, 1 bit: high once the post-reset clear is complete.
REQ-009 The module SHALL have port mem_fault, output, 1 bit: sticky flag for any out-of-range access attempt.

Function
REQ-010 Storage SHALL be a byte array of MEM_BYTES entries, addressed big-endian by lane: lane 0 at the lowest address.
REQ-011 Two-state FSM: CLEAR and READY.
REQ-012 CLEAR SHALL write zero to 4 bytes at clr_ptr per cycle and then increment clr_ptr by 4.
REQ-013 The CLEAR cycle that writes clr_ptr = MEM_BYTES-4 SHALL transition to READY; CLEAR lasts exactly MEM_BYTES/4 cycles.
REQ-014 READY SHALL be terminal until reset; mem_ready = (state == READY), registered.
REQ-015 In CLEAR, mem_data_out SHALL be all-zero and mem_write_en SHALL be ignored, with no write and no fault.
REQ-016 In READY, reads SHALL be combinational: mem_data_out reflects the array contents at mem_addr..mem_addr+3 in the same cycle.
REQ-017 In READY, when mem_write_en=1 and the access is in range, all 4 lanes SHALL be written at the rising edge.
REQ-018 A same-cycle read of a location being written SHALL return the old value; the new value is visible after the edge.
REQ-019 Any alignment SHALL be legal; no alignment fault exists.
REQ-020 In-range SHALL be defined as (mem_addr + 3) < MEM_BYTES, computed at 33-bit width so that addresses 0xFFFFFFFD..0xFFFFFFFF are out of range; no wrap-around.
REQ-021 An out-of-range read in READY SHALL return all-zero lanes and SHALL set mem_fault.
REQ-022 An out-of-range write in READY SHALL be suppressed entirely (no partial lanes) and SHALL set mem_fault.
REQ-023 mem_fault SHALL set at the edge following the offending cycle and remain high until reset.

Reset
REQ-024 Reset assertion SHALL immediately set state=CLEAR, clr_ptr=0, mem_ready=0, mem_fault=0.
REQ-025 The array SHALL NOT be reset directly; it is zeroed only by the CLEAR sweep.
REQ-026 Reset asserted during CLEAR SHALL restart the sweep from 0; a full MEM_BYTES/4 cycles are required after release.
REQ-027 Reset asserted during READY SHALL return the block to CLEAR; prior contents are lost.

Structure
REQ-028 Package mips_mem_pkg SHALL hold the mem_state_t enum {CLEAR, READY}, WORD_BYTES=4 and the byte_lanes_t type ([7:0] x [0:3]); these are shared with the core side.
REQ-029 The clear sequencer (FSM + clr_ptr) SHALL be one sub-module, mem_clear_seq, outputting clr_we, clr_addr and done; the array and range check stay in the top module.

Verification (MEM_BYTES=64)
REQ-030 Release reset, then poll with addr 0 -> mem_ready=0 for 16 cycles and 1 from cycle 17; mem_data_out = 0 throughout.
REQ-031 READY; write addr 8 = {AA,BB,CC,DD} -> next cycle, read addr 8 = {AA,BB,CC,DD} and read addr 9 = {BB,CC,DD,00}.
REQ-032 READY; write addr 61 = {11,22,33,44} -> mem_fault=1 on the next edge and stays high; bytes 61..63 remain 00; read addr 61 returns zeros.
REQ-033 Write addr 0 = {FF,FF,FF,FF} at CLEAR cycle 3 -> no fault; after READY, read addr 0 = zeros.
REQ-034 Assert rst_b=0 at CLEAR cycle 5, then release -> mem_ready rises exactly 16 cycles after release; mem_fault=0.
REQ-035 Write addr 4 = {01,02,03,04} with a same-cycle read -> old value that cycle; {01,02,03,04} the cycle after.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Types and constants shared between the data memory and the core side.
package mips_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } mem_state_t;

  localparam int WORD_BYTES = 4;

  // Lane 0 is the outermost (most significant) slice, so a 32-bit literal
  // such as 32'hAABBCCDD places AA in lane 0 at the lowest address.
  typedef logic [0:WORD_BYTES-1][7:0] byte_lanes_t;

endpackage

// File: rtl/mem_clear_seq.sv
// Post-reset clear sequencer: sweeps the data memory four bytes per cycle,
// then parks in READY until the next reset.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   CLEAR | zeroing WORD_BYTES bytes at clr_ptr each cycle, ptr += 4
//   READY | sweep finished; terminal until rst_b is asserted
module mem_clear_seq
  import mips_mem_pkg::*;
#(
  parameter int MEM_BYTES = 8192,
  localparam int AW = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic          rst_b,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          done
);

  localparam logic [AW-1:0] LAST_PTR = AW'(MEM_BYTES - WORD_BYTES);
  localparam logic [AW-1:0] PTR_STEP = AW'(WORD_BYTES);

  mem_state_t    state;
  logic [AW-1:0] clr_ptr;

  // Sweep pointer and state; done is registered alongside the state so it
  // rises on the same edge that retires the final clear word.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      done    <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + PTR_STEP;
          if (clr_ptr == LAST_PTR) begin
            state <= READY;
            done  <= 1'b1;
          end
        end
        READY: begin
          state <= READY;
          done  <= 1'b1;
        end
        default: begin
          state <= CLEAR;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we   = (state == CLEAR);
  assign clr_addr = clr_ptr;

endmodule

// File: rtl/mips_data_mem.sv
// Byte-addressed data memory with 4-lane unaligned access, a post-reset
// clear sweep and a sticky out-of-range fault flag.
module mips_data_mem
  import mips_mem_pkg::*;
#(
  parameter int MEM_BYTES = 8192
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [31:0] mem_addr,
  input  byte_lanes_t mem_data_in,
  input  logic        mem_write_en,
  output byte_lanes_t mem_data_out,
  output logic        mem_ready,
  output logic        mem_fault
);

  localparam int AW = $clog2(MEM_BYTES);

  logic [7:0]    mem [MEM_BYTES];
  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          done;
  logic          in_range;
  logic [AW-1:0] base;

  mem_clear_seq #(
    .MEM_BYTES(MEM_BYTES)
  ) u_clear_seq (
    .clk     (clk),
    .rst_b   (rst_b),
    .clr_we  (clr_we),
    .clr_addr(clr_addr),
    .done    (done)
  );

  // 33-bit sum so addresses near 2^32 cannot wrap back into range.
  assign in_range = (({1'b0, mem_addr} + 33'd3) < 33'(MEM_BYTES));
  assign base     = mem_addr[AW-1:0];

  // Combinational read; zero while clearing or when any lane is out of range.
  always_comb begin
    mem_data_out = '0;
    if (done && in_range) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        mem_data_out[i] = mem[base + AW'(i)];
      end
    end
  end

  // Array write port: the clear sweep owns it until done, then the core.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        mem[clr_addr + AW'(i)] <= 8'h00;
      end
    end else if (done && mem_write_en && in_range) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        mem[base + AW'(i)] <= mem_data_in[i];
      end
    end
  end

  // Sticky fault: every READY cycle is a read, so any out-of-range address sets it.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mem_fault <= 1'b0;
    end else if (done && !in_range) begin
      mem_fault <= 1'b1;
    end
  end

  assign mem_ready = done;

endmodule

// File: tb/tb_mips_data_mem.sv
// Directed bench for mips_data_mem at MEM_BYTES=64.
module tb_mips_data_mem;
  import mips_mem_pkg::*;

  localparam int MB = 64;

  logic        clk;
  logic        rst_b;
  logic [31:0] mem_addr;
  byte_lanes_t mem_data_in;
  logic        mem_write_en;
  byte_lanes_t mem_data_out;
  logic        mem_ready;
  logic        mem_fault;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] din;
    logic        we;
    logic [31:0] dout;
    logic        fault;
  } vec_t;

  vec_t vecs[$];

  mips_data_mem #(.MEM_BYTES(MB)) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .mem_addr    (mem_addr),
    .mem_data_in (mem_data_in),
    .mem_write_en(mem_write_en),
    .mem_data_out(mem_data_out),
    .mem_ready   (mem_ready),
    .mem_fault   (mem_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_lanes(input string nm, input byte_lanes_t got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic chk_bit(input string nm, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // addr, din, we, expected dout (same cycle), expected fault (same cycle)
    vecs.push_back('{32'd8,          32'hAABBCCDD, 1'b1, 32'h00000000, 1'b0});
    vecs.push_back('{32'd8,          32'h0,        1'b0, 32'hAABBCCDD, 1'b0});
    vecs.push_back('{32'd9,          32'h0,        1'b0, 32'hBBCCDD00, 1'b0});
    vecs.push_back('{32'd7,          32'h0,        1'b0, 32'h00AABBCC, 1'b0});
    vecs.push_back('{32'd4,          32'h01020304, 1'b1, 32'h00000000, 1'b0});
    vecs.push_back('{32'd4,          32'h0,        1'b0, 32'h01020304, 1'b0});
    vecs.push_back('{32'd6,          32'h0,        1'b0, 32'h0304AABB, 1'b0});
    vecs.push_back('{32'd56,         32'h55667788, 1'b1, 32'h00000000, 1'b0});
    vecs.push_back('{32'd56,         32'h0,        1'b0, 32'h55667788, 1'b0});
    vecs.push_back('{32'd60,         32'h0,        1'b0, 32'h00000000, 1'b0});
    vecs.push_back('{32'd61,         32'h11223344, 1'b1, 32'h00000000, 1'b0});
    vecs.push_back('{32'd58,         32'h0,        1'b0, 32'h77880000, 1'b1});
    vecs.push_back('{32'd61,         32'h0,        1'b0, 32'h00000000, 1'b1});
    vecs.push_back('{32'd60,         32'h0,        1'b0, 32'h00000000, 1'b1});
    vecs.push_back('{32'hFFFFFFFE,   32'h9ABCDEF0, 1'b1, 32'h00000000, 1'b1});
    vecs.push_back('{32'd0,          32'h0,        1'b0, 32'h00000000, 1'b1});
    vecs.push_back('{32'd4,          32'h0,        1'b0, 32'h01020304, 1'b1});

    rst_b        = 1'b0;
    mem_addr     = 32'd0;
    mem_data_in  = '0;
    mem_write_en = 1'b0;
    #2;
    chk_bit("reset_ready", mem_ready, 1'b0);
    chk_bit("reset_fault", mem_fault, 1'b0);

    // Initial sweep: poll addr 0, with a write attempt during CLEAR cycle 3.
    @(posedge clk); #1;
    rst_b = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      mem_addr     = 32'd0;
      mem_write_en = (c == 3);
      mem_data_in  = (c == 3) ? 32'hFFFFFFFF : 32'h0;
      @(negedge clk);
      chk_bit($sformatf("sweep_ready_c%0d", c), mem_ready, (c >= 17));
      chk_lanes($sformatf("sweep_data_c%0d", c), mem_data_out, 32'h0);
      @(posedge clk); #1;
    end
    mem_write_en = 1'b0;
    chk_bit("sweep_fault", mem_fault, 1'b0);

    foreach (vecs[k]) begin
      mem_addr     = vecs[k].addr;
      mem_data_in  = vecs[k].din;
      mem_write_en = vecs[k].we;
      @(negedge clk);
      chk_lanes($sformatf("vec%0d_data", k), mem_data_out, vecs[k].dout);
      chk_bit($sformatf("vec%0d_fault", k), mem_fault, vecs[k].fault);
      @(posedge clk); #1;
    end
    mem_write_en = 1'b0;
    chk_bit("fault_sticky", mem_fault, 1'b1);

    // Reset from READY clears ready and fault immediately.
    mem_addr = 32'd8;
    rst_b    = 1'b0;
    #1;
    chk_bit("rst_ready_async", mem_ready, 1'b0);
    chk_bit("rst_fault_async", mem_fault, 1'b0);
    @(negedge clk);
    rst_b = 1'b1;

    // Re-assert reset at CLEAR cycle 5, then time the full sweep.
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
    end
    chk_bit("clear_c5_ready", mem_ready, 1'b0);
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    n = 0;
    while (!mem_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (!mem_ready) chk_lanes($sformatf("restart_data_e%0d", n), mem_data_out, 32'h0);
    end
    n_vec++;
    if (n != 16) begin
      n_bad++;
      $display("FAIL restart_latency: got %0d edges want 16", n);
    end
    chk_bit("restart_fault", mem_fault, 1'b0);
    chk_lanes("contents_lost", mem_data_out, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
